// File: rtl/sw_debouncer.sv
// ----------------------------------------------------------------------------
// sw_debouncer
//
// Conditions the raw slide-switch bus before it reaches the LED shift-register
// top level. Each switch bit goes through a two-flop synchronizer and then
// through its own counter-based debouncer. A bit's new level is accepted only
// after the synchronized input has disagreed with the accepted level for
// DEBOUNCE_LIMIT consecutive cycles. Any bounce back to the accepted level
// restarts the hold window from zero.
//
// Ports:
//   clock        in   1      system clock, all state updates on rising edge
//   i_reset      in   1      synchronous, active-high reset
//   i_sw         in   NB_SW  raw asynchronous switch inputs
//   o_sw         out  NB_SW  debounced, stable switch vector
//   o_sw_rise    out  NB_SW  per-bit one-cycle pulse on an o_sw 0->1 change
//   o_sw_fall    out  NB_SW  per-bit one-cycle pulse on an o_sw 1->0 change
//   o_sw_change  out  1      one-cycle pulse when any bit rises or falls
//
// Parameters:
//   NB_SW           number of switch bits conditioned
//   NB_COUNTER      width of each per-bit debounce counter
//   DEBOUNCE_LIMIT  hold time in cycles, legal range 1 .. 2**NB_COUNTER-1
// ----------------------------------------------------------------------------
module sw_debouncer #(
    parameter int NB_SW          = 4,
    parameter int NB_COUNTER     = 14,
    parameter int DEBOUNCE_LIMIT = 10000
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic [NB_SW-1:0] i_sw,
    output logic [NB_SW-1:0] o_sw,
    output logic [NB_SW-1:0] o_sw_rise,
    output logic [NB_SW-1:0] o_sw_fall,
    output logic             o_sw_change
);

    // Counter value on the last cycle of the hold window. Reaching it while
    // the input still disagrees commits the new level on this edge, so the
    // counter never needs to count past it and cannot wrap.
    localparam logic [NB_COUNTER-1:0] LAST_COUNT = NB_COUNTER'(DEBOUNCE_LIMIT - 1);
    localparam logic [NB_COUNTER-1:0] COUNT_ONE  = NB_COUNTER'(1);

    logic [NB_SW-1:0]      syncFirst_q;
    logic [NB_SW-1:0]      syncSecond_q;

    logic [NB_SW-1:0]      stable_q;
    logic [NB_SW-1:0]      stable_d;
    logic [NB_SW-1:0]      rise_q;
    logic [NB_SW-1:0]      rise_d;
    logic [NB_SW-1:0]      fall_q;
    logic [NB_SW-1:0]      fall_d;
    logic [NB_COUNTER-1:0] count_q [NB_SW];
    logic [NB_COUNTER-1:0] count_d [NB_SW];

    // Two-flop synchronizer. The first stage may go metastable; only the
    // second stage is ever looked at by the debounce logic.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            syncFirst_q  <= '0;
            syncSecond_q <= '0;
        end else begin
            syncFirst_q  <= i_sw;
            syncSecond_q <= syncFirst_q;
        end
    end

    // Per-bit debounce decision. A bit whose synchronized input agrees with
    // the accepted level just keeps its counter at zero. A disagreeing bit
    // counts up, and on the last count of the window it takes the new level
    // and raises the rise or fall strobe that matches the direction. Strobes
    // default low, so they last exactly one cycle.
    always_comb begin
        stable_d = stable_q;
        rise_d   = '0;
        fall_d   = '0;
        for (int b = 0; b < NB_SW; b++) begin
            count_d[b] = count_q[b];
            if (syncSecond_q[b] == stable_q[b]) begin
                count_d[b] = '0;
            end else if (count_q[b] == LAST_COUNT) begin
                stable_d[b] = syncSecond_q[b];
                count_d[b]  = '0;
                rise_d[b]   = syncSecond_q[b];
                fall_d[b]   = ~syncSecond_q[b];
            end else begin
                count_d[b] = count_q[b] + COUNT_ONE;
            end
        end
    end

    // Debounce state registers. Reset wipes any count in progress so every
    // bit restarts from an accepted level of 0.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            stable_q <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            for (int b = 0; b < NB_SW; b++) begin
                count_q[b] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            for (int b = 0; b < NB_SW; b++) begin
                count_q[b] <= count_d[b];
            end
        end
    end

    // The change pulse is derived from the registered strobes, so it lines up
    // with them and is a single pulse even when several bits move together.
    always_comb begin
        o_sw        = stable_q;
        o_sw_rise   = rise_q;
        o_sw_fall   = fall_q;
        o_sw_change = |(rise_q | fall_q);
    end

endmodule
